// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the DataMemory arbiter.
//   arb_state_t    arbiter FSM states (IDLE, LOCK0, LOCK1)
//   dmem_req_t     one requester's access bundle {we, addr, wdata, lock}
//   addr_in_range  true when a word address falls inside DataMemory
package dmem_pkg;

  localparam int DMEM_DEPTH  = 32;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                   we;
    logic [DMEM_DATA_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic                   lock;
  } dmem_req_t;

  function automatic logic addr_in_range(input logic [DMEM_DATA_W-1:0] addr,
                                         input logic [DMEM_DATA_W-1:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker.
//   i_req[1:0]  request vector (bit N = port N)
//   i_last      port granted most recently; on a tie the other port wins
//   o_gnt[1:0]  one-hot grant, zero when nothing requests
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // Pick the single requester, or on a tie the port that did not go last
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DataMemory between the core (port 0)
// and the loader/debug DMA (port 1), one access per cycle, round-robin with
// an optional burst lock.
//   clk, reset                        clock, synchronous active-high reset
//   mN_req/we/addr/wdata/lock (in)    requester N access; held until mN_gnt
//   mN_gnt (out)                      access accepted this cycle (combinational)
//   mN_rvalid/rdata/err (out)         response one cycle after the grant
//   mem_we/addr/wdata (out)           DataMemory write enable, address, data
//   mem_rdata (in)                    DataMemory combinational read data
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic [1:0]        w_pick;
  logic [1:0]        w_gnt;
  logic              w_any_gnt;
  logic              w_sel_ok;
  logic [DATA_W-1:0] w_rd_data;
  dmem_req_t         w_req0;
  dmem_req_t         w_req1;
  dmem_req_t         w_sel;
  logic [1:0]        r_rvalid;
  logic [1:0]        r_err;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  assign w_req0 = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, lock: m0_lock};
  assign w_req1 = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, lock: m1_lock};

  rr_pick2 u_pick (
    .i_req  ({m1_req, m0_req}),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // Grant selection and next state; a locked port is never preempted
  always_comb begin
    w_gnt       = 2'b00;
    w_state_nxt = IDLE;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE:    w_gnt = w_pick;
      LOCK0:   w_gnt = {1'b0, m0_req};
      LOCK1:   w_gnt = {m1_req, 1'b0};
      default: w_gnt = 2'b00;
    endcase
    if (reset) begin
      w_gnt = 2'b00;
    end else begin
      w_gnt = w_gnt;
    end
    // Owner dropping req (or no grant at all) falls back to IDLE
    if (w_gnt[0]) begin
      w_state_nxt = m0_lock ? LOCK0 : IDLE;
      w_last_nxt  = 1'b0;
    end else if (w_gnt[1]) begin
      w_state_nxt = m1_lock ? LOCK1 : IDLE;
      w_last_nxt  = 1'b1;
    end else begin
      w_state_nxt = IDLE;
      w_last_nxt  = r_last;
    end
  end

  // Route the granted port onto the memory bus; out-of-range writes are dropped
  always_comb begin
    w_any_gnt = |w_gnt;
    w_sel     = w_gnt[1] ? w_req1 : w_req0;
    w_sel_ok  = addr_in_range(w_sel.addr, DMEM_DATA_W'(DEPTH));
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_any_gnt) begin
      mem_addr  = w_sel.addr;
      mem_wdata = w_sel.wdata;
    end else begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
    mem_we    = w_any_gnt & w_sel.we & w_sel_ok;
    w_rd_data = (w_any_gnt & ~w_sel.we & w_sel_ok) ? mem_rdata : '0;
  end

  // FSM state, round-robin history and per-port response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_rvalid <= 2'b00;
      r_err    <= 2'b00;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_rvalid <= w_gnt;
      r_err    <= w_gnt & {2{~w_sel_ok}};
      r_rdata0 <= w_gnt[0] ? w_rd_data : '0;
      r_rdata1 <= w_gnt[1] ? w_rd_data : '0;
    end
  end

  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];

  // Responses are masked while reset is high so an in-flight one is squashed
  assign m0_rvalid = r_rvalid[0] & ~reset;
  assign m1_rvalid = r_rvalid[1] & ~reset;
  assign m0_err    = r_err[0] & ~reset;
  assign m1_err    = r_err[1] & ~reset;
  assign m0_rdata  = reset ? '0 : r_rdata0;
  assign m1_rdata  = reset ? '0 : r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        tb_init;
  logic [1:0]  req, we, lock;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] dmem [32];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_owner;
  int          m_last;
  logic [31:0] model_mem [32];
  logic [1:0]  pend_v, pend_e;
  logic [31:0] pend_d [2];

  // Observations from the most recent step
  logic [1:0]  obs_gnt, obs_rv, obs_err;
  logic        obs_we;
  logic [31:0] obs_rd [2];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_lock(lock[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_lock(lock[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // DataMemory stand-in: combinational read, write at the clock edge
  assign mem_rdata = dmem[mem_addr[4:0]];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) dmem[i] <= 32'hA000_0000 + 32'(i);
    end else if (mem_we) begin
      dmem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic l);
    req[p] = r; we[p] = w; addr[p] = a; wdata[p] = d; lock[p] = l;
  endtask

  // One cycle: compare DUT against the model at the falling edge, then advance the model
  task automatic step();
    int g;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    g = -1;
    if (!reset) begin
      if (m_owner >= 0) begin
        if (req[m_owner]) g = m_owner;
      end else if (req[0] && req[1]) g = 1 - m_last;
      else if (req[0]) g = 0;
      else if (req[1]) g = 1;
    end
    obs_gnt = {m1_gnt, m0_gnt};
    obs_we  = mem_we;
    obs_rv  = {m1_rvalid, m0_rvalid};
    obs_err = {m1_err, m0_err};
    obs_rd[0] = m0_rdata;
    obs_rd[1] = m1_rdata;
    e_we = 1'b0; e_addr = 32'd0; e_wdata = 32'd0;
    if (g >= 0) begin
      e_we = we[g] && (addr[g] < 32'd32);
      e_addr = addr[g];
      e_wdata = wdata[g];
    end
    chk("gnt", {30'd0, obs_gnt}, (g == 0) ? 32'd1 : (g == 1) ? 32'd2 : 32'd0);
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    for (int p = 0; p < 2; p++) begin
      chk("rvalid", {31'd0, obs_rv[p]}, reset ? 32'd0 : {31'd0, pend_v[p]});
      chk("err", {31'd0, obs_err[p]}, reset ? 32'd0 : {31'd0, pend_e[p]});
      chk("rdata", obs_rd[p], reset ? 32'd0 : pend_d[p]);
    end
    pend_v = 2'b00; pend_e = 2'b00; pend_d[0] = 32'd0; pend_d[1] = 32'd0;
    if (reset) begin
      m_owner = -1;
      m_last = 1;
    end else if (g >= 0) begin
      pend_v[g] = 1'b1;
      pend_e[g] = (addr[g] >= 32'd32);
      if (!we[g] && !pend_e[g]) pend_d[g] = model_mem[addr[g][4:0]];
      if (we[g] && !pend_e[g]) model_mem[addr[g][4:0]] = wdata[g];
      m_last = g;
      m_owner = lock[g] ? g : -1;
    end else begin
      m_owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        r0, w0; logic [31:0] a0, d0;
    logic        r1, w1; logic [31:0] a1, d1;
    logic [1:0]  e_gnt, e_rv;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  vec_t vecs [10];
  logic [1:0] busy;

  initial begin
    reset = 1'b1; tb_init = 1'b1; req = 2'b00; we = 2'b00; lock = 2'b00;
    for (int p = 0; p < 2; p++) begin addr[p] = 32'd0; wdata[p] = 32'd0; end
    for (int i = 0; i < 32; i++) model_mem[i] = 32'hA000_0000 + 32'(i);
    m_owner = -1; m_last = 1; pend_v = 2'b00; pend_e = 2'b00;
    pend_d[0] = 32'd0; pend_d[1] = 32'd0;
    @(posedge clk);
    #1;
    tb_init = 1'b0;

    // Reset with both requesting, round-robin contention, write then read-back
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h3, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h3, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h3, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b01, 2'b00, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h3, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b10, 2'b01, 32'hA0000003, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h3, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b01, 2'b10, 32'h0, 32'hA0000004};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h3, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b10, 2'b01, 32'hA0000003, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h7, 32'hDEADBEEF, 2'b10, 2'b10, 32'h0, 32'hA0000004};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h7, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b01, 2'b10, 32'h0, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b01, 32'hDEADBEEF, 32'h0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      reset = vecs[i].rst;
      set_port(0, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0, 1'b0);
      set_port(1, vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1, 1'b0);
      step();
      chk("vec_gnt", {30'd0, obs_gnt}, {30'd0, vecs[i].e_gnt});
      chk("vec_rvalid", {30'd0, obs_rv}, {30'd0, vecs[i].e_rv});
      chk("vec_rdata0", obs_rd[0], vecs[i].e_rd0);
      chk("vec_rdata1", obs_rd[1], vecs[i].e_rd1);
    end

    // Lock burst: m1 holds four writes, m0 waits, lock released by dropping req
    set_port(0, 1'b1, 1'b0, 32'h1, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      set_port(1, 1'b1, 1'b1, 32'h10 + 32'(k), 32'hB000_0010 + 32'(k), 1'b1);
      step();
      chk("burst_m1_only", {30'd0, obs_gnt}, 32'd2);
    end
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("lock_drop_idle", {30'd0, obs_gnt}, 32'd0);
    step();
    chk("after_lock_m0", {30'd0, obs_gnt}, 32'd1);
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("after_lock_rdata", obs_rd[0], 32'hA000_0001);
    for (int k = 0; k < 4; k++) chk("burst_mem", dmem[16 + k], 32'hB000_0010 + 32'(k));

    // Out-of-range write
    set_port(0, 1'b1, 1'b1, 32'h20, 32'h55, 1'b0);
    step();
    chk("oor_mem_we", {31'd0, obs_we}, 32'd0);
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("oor_err", {31'd0, obs_err[0]}, 32'd1);
    chk("oor_rdata", obs_rd[0], 32'd0);
    chk("oor_dmem0", dmem[0], 32'hA000_0000);

    // Reset while m0 holds a lock with a read in flight
    set_port(0, 1'b1, 1'b0, 32'h2, 32'h0, 1'b1);
    step();
    chk("lock0_gnt", {30'd0, obs_gnt}, 32'd1);
    reset = 1'b1;
    set_port(1, 1'b1, 1'b0, 32'h5, 32'h0, 1'b0);
    step();
    chk("squash_rvalid", {30'd0, obs_rv}, 32'd0);
    chk("squash_gnt", {30'd0, obs_gnt}, 32'd0);
    reset = 1'b0;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("post_reset_m1", {30'd0, obs_gnt}, 32'd2);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("post_reset_rdata", obs_rd[1], 32'hA000_0005);

    // Randomized traffic honouring the hold-until-grant rule
    busy = 2'b00;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < 2; p++) begin
        if (!busy[p]) begin
          if ($urandom_range(0, 9) < 7) begin
            busy[p] = 1'b1;
            set_port(p, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 39)),
                     $urandom, ($urandom_range(0, 3) == 0));
          end else begin
            set_port(p, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
          end
        end
      end
      step();
      for (int p = 0; p < 2; p++) if (obs_gnt[p]) busy[p] = 1'b0;
    end
    reset = 1'b0;
    for (int i = 0; i < 32; i++) chk("final_mem", dmem[i], model_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
